// File: rtl/horner_pkg.sv
// Shared definitions for the Horner evaluator and its coefficient feeder.
package horner_pkg;
  localparam int HORNER_DATA_W  = 32;
  localparam int HORNER_MAX_DEG = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/horner_coeff_ram.sv
// Coefficient store: DEPTH x DATA_W registers, synchronous write/clear, combinational read.
// Out-of-range writes are dropped; out-of-range reads return zero.
module horner_coeff_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;
endmodule

// File: rtl/horner_coeff_feeder.sv
// Streams stored coefficients highest-degree-first to the evaluator (first beat 1 cycle after start),
// holding each beat while ev_ready is low, then captures the result and pulses z_valid for one cycle.
module horner_coeff_feeder
  import horner_pkg::*;
#(
  parameter int DATA_W  = HORNER_DATA_W,
  parameter int MAX_DEG = HORNER_MAX_DEG,
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = $clog2(MAX_DEG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [ADDR_W-1:0] cfg_deg,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  output logic              busy,
  output logic [DATA_W-1:0] ev_x,
  output logic [DATA_W-1:0] ev_coef,
  output logic              ev_coef_valid,
  output logic              ev_first,
  output logic              ev_last,
  input  logic              ev_ready,
  input  logic [DATA_W-1:0] ev_result,
  input  logic              ev_result_valid,
  output logic [DATA_W-1:0] z,
  output logic              z_valid,
  output logic              timeout_err
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] z_q, z_d;
  logic [ADDR_W-1:0] deg_q, deg_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] deg_clamped;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;

  // The store is frozen for the whole evaluation so the stream sees a consistent polynomial.
  assign ram_we      = cfg_we && (state_q == ST_IDLE);
  assign deg_clamped = (32'(cfg_deg) > MAX_DEG) ? ADDR_W'(MAX_DEG) : cfg_deg;

  horner_coeff_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DEG + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      z_q   <= '0;
      deg_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      z_q   <= z_d;
      deg_q <= deg_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    z_d     = z_q;
    deg_d   = deg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x_in;
          deg_d   = deg_clamped;
          idx_d   = deg_clamped;
          err_d   = 1'b0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (ev_ready) begin
          if (idx_q == '0) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            idx_d = idx_q - ADDR_W'(1);
          end
        end
      end
      ST_WAIT: begin
        // A result arriving on the final allowed cycle still wins over the timeout.
        if (ev_result_valid) begin
          z_d     = ev_result;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    ev_x          = x_q;
    ev_coef_valid = (state_q == ST_STREAM);
    ev_coef       = (state_q == ST_STREAM) ? ram_rdata : '0;
    ev_first      = (state_q == ST_STREAM) && (idx_q == deg_q);
    ev_last       = (state_q == ST_STREAM) && (idx_q == '0);
    z             = z_q;
    z_valid       = (state_q == ST_DONE);
    timeout_err   = err_q;
  end
endmodule
